ram_port_arbiter: RTL

//  Shares the single-port data RAM between two bus masters.
//  - Master 0: ARM core data port.
//  - Master 1: a DMA/peripheral master.

---
 rtl/ram_port_arbiter_if.sv | 47 ++++
 rtl/ram_port_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM masters, the arbiter and the RAM macro.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and models the RAM.
interface ram_port_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 8
);
    logic             req0;
    logic             we0;
    logic [AW-1:0]    addr0;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] rdata0;
    logic             ack0;

    logic             req1;
    logic             we1;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] wdata1;
    logic [WIDTH-1:0] rdata1;
    logic             ack1;

    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    logic             busy;
    logic             grant;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output rdata0, ack0, rdata1, ack1,
        output mem_addr, mem_wdata, mem_we,
        output busy, grant
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  rdata0, ack0, rdata1, ack1,
        input  mem_addr, mem_wdata, mem_we,
        input  busy, grant
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the
// core data port (master 0) and a DMA/peripheral master (master 1).
// Each transaction runs IDLE -> ACCESS -> ACK -> IDLE with registered outputs.
// A read keeps the address on the RAM for READ_LAT+2 cycles: READ_LAT cycles
// of RAM latency plus the cycle in which the RAM samples the registered address
// and one settle cycle, so mem_rdata is captured well after it became stable.
module ram_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int AW       = 8,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    ram_port_arbiter_if.slave  bus
);
    localparam logic [2:0] LAST_CNT = 3'(READ_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } state_t;

    state_t           state;
    logic             grant_r;
    logic             op_we_r;
    logic [2:0]       lat_cnt_r;
    logic             ack0_r;
    logic             ack1_r;
    logic [WIDTH-1:0] rdata0_r;
    logic [WIDTH-1:0] rdata1_r;
    logic [AW-1:0]    mem_addr_r;
    logic [WIDTH-1:0] mem_wdata_r;
    logic             mem_we_r;
    logic             busy_r;

    logic             winner_s;
    logic             any_req_s;

    // Next winner: the lone requester, or on a tie the master that did not win last.
    always_comb begin
        any_req_s = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            winner_s = ~grant_r;
        end else if (bus.req1) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Transaction sequencer: arbitration, RAM strobes, read capture and ack pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_r     <= 1'b1;
            op_we_r     <= 1'b0;
            lat_cnt_r   <= 3'd0;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            rdata0_r    <= '0;
            rdata1_r    <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    if (any_req_s) begin
                        state     <= ACCESS;
                        busy_r    <= 1'b1;
                        grant_r   <= winner_s;
                        lat_cnt_r <= 3'd0;
                        if (winner_s) begin
                            op_we_r     <= bus.we1;
                            mem_we_r    <= bus.we1;
                            mem_addr_r  <= bus.addr1;
                            mem_wdata_r <= bus.wdata1;
                        end else begin
                            op_we_r     <= bus.we0;
                            mem_we_r    <= bus.we0;
                            mem_addr_r  <= bus.addr0;
                            mem_wdata_r <= bus.wdata0;
                        end
                    end else begin
                        // Address and data are left as they were: no glitch to 0.
                        state    <= IDLE;
                        busy_r   <= 1'b0;
                        mem_we_r <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (op_we_r) begin
                        // Write strobe was high for exactly this one cycle.
                        mem_we_r <= 1'b0;
                        state    <= ACK;
                        ack0_r   <= ~grant_r;
                        ack1_r   <= grant_r;
                    end else if (lat_cnt_r == LAST_CNT) begin
                        state  <= ACK;
                        ack0_r <= ~grant_r;
                        ack1_r <= grant_r;
                        if (grant_r) begin
                            rdata1_r <= bus.mem_rdata;
                        end else begin
                            rdata0_r <= bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 3'd1;
                    end
                end
                ACK: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    ack0_r   <= 1'b0;
                    ack1_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    mem_we_r <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = ack0_r;
    assign bus.ack1      = ack1_r;
    assign bus.rdata0    = rdata0_r;
    assign bus.rdata1    = rdata1_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.busy      = busy_r;
    assign bus.grant     = grant_r;
endmodule
